cpu_frame_ctrl: RTL and testbench

Sequencer for the CPU access path of the GF(257) 4x24 LDPC decoder. It drives the enable of the 24-bank CPU address generator and the bank read and write strobes, and it hands frames to the decoder core. The flow for each frame is: load DEPTH words into the 24 column banks in parallel, start the decoder, wait for it to finish, then stream the decoded words back out. It sits between the CPU-side stream interface and the address generator / column memories.

---
 rtl/cpu_frame_ctrl_pkg.sv | 21 ++
 rtl/cpu_frame_ctrl_if.sv | 29 ++
 rtl/cpu_frame_ctrl_vld_delay.sv | 24 ++
 rtl/cpu_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpu_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_frame_ctrl_pkg.sv
// Shared definitions for the CPU frame sequencer of the GF(257) 4x24 LDPC decoder.
package cpu_frame_ctrl_pkg;

  // Column banks written and read in parallel by the CPU path
  localparam int unsigned NumBanks = 24;

  // Supported bank read latency range
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDecStart,
    StDecWait,
    StGap,
    StUnload,
    StDrain
  } state_e;

endpackage

// File: rtl/cpu_frame_ctrl_if.sv
// Handshake, strobe and decoder-control signals of the CPU frame sequencer.
interface cpu_frame_ctrl_if;
  logic load_req;
  logic in_valid;
  logic in_ready;
  logic cpu_addr_ena;
  logic mem_wr_en;
  logic mem_rd_en;
  logic out_valid;
  logic dec_start;
  logic dec_done;
  logic busy;
  logic frame_done;
  logic err;

  // Sequencer side
  modport slave (
    input  load_req, in_valid, dec_done,
    output in_ready, cpu_addr_ena, mem_wr_en, mem_rd_en, out_valid,
           dec_start, busy, frame_done, err
  );

  // CPU stream / decoder side
  modport master (
    output load_req, in_valid, dec_done,
    input  in_ready, cpu_addr_ena, mem_wr_en, mem_rd_en, out_valid,
           dec_start, busy, frame_done, err
  );
endinterface

// File: rtl/cpu_frame_ctrl_vld_delay.sv
// Fixed-latency delay line for a single valid bit.
module cpu_frame_ctrl_vld_delay #(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_vld
);

  logic [LAT-1:0] r_pipe;

  // Shift the valid bit one stage per cycle; the MSB is the delayed output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | LAT'(i_vld);
    end
  end

  assign o_vld = r_pipe[LAT-1];

endmodule

// File: rtl/cpu_frame_ctrl.sv
// Frame sequencer for the CPU access path: load banks, run decoder, unload banks.
module cpu_frame_ctrl
  import cpu_frame_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned RD_LAT     = 1
) (
  input logic          clk,
  input logic          rst_n,
  cpu_frame_ctrl_if.slave bus
);

  // One extra bit so DEPTH = 2^ADDR_WIDTH is representable
  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] LastBeat  = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] LastDrain = CntW'(RD_LAT - 1);

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_err, w_err_nxt;

  logic w_in_ready;
  logic w_addr_ena;
  logic w_wr_en;
  logic w_rd_en;
  logic w_dec_start;
  logic w_frame_done;
  logic w_out_valid;

  // State, beat counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, counter and error decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (bus.load_req) begin
          w_state_nxt = StLoad;
          w_err_nxt   = 1'b0;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (r_cnt == LastBeat) begin
            w_state_nxt = StDecStart;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (r_cnt != '0) begin
          // Stream stalled after the burst began: abandon the frame
          w_err_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StDecStart: w_state_nxt = StDecWait;
      StDecWait: begin
        if (bus.dec_done) begin
          w_state_nxt = StGap;
        end
      end
      StGap: w_state_nxt = StUnload;
      StUnload: begin
        if (r_cnt == LastBeat) begin
          w_state_nxt = StDrain;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDrain: begin
        if (r_cnt == LastDrain) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // Every state starts counting from zero
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end
  end

  // Strobes and handshakes decoded from the current state
  always_comb begin
    w_in_ready   = 1'b0;
    w_addr_ena   = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_dec_start  = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      StLoad: begin
        w_in_ready = 1'b1;
        // Enable low while waiting keeps the generator parked at 0
        w_wr_en    = bus.in_valid;
        w_addr_ena = bus.in_valid;
      end
      StDecStart: w_dec_start = 1'b1;
      StUnload: begin
        w_rd_en    = 1'b1;
        w_addr_ena = 1'b1;
      end
      StDrain: w_frame_done = (r_cnt == LastDrain);
      default: ;
    endcase
  end

  cpu_frame_ctrl_vld_delay #(
    .LAT (RD_LAT)
  ) u_vld_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (w_rd_en),
    .o_vld (w_out_valid)
  );

  assign bus.in_ready     = w_in_ready;
  assign bus.cpu_addr_ena = w_addr_ena;
  assign bus.mem_wr_en    = w_wr_en;
  assign bus.mem_rd_en    = w_rd_en;
  assign bus.out_valid    = w_out_valid;
  assign bus.dec_start    = w_dec_start;
  assign bus.busy         = (r_state != StIdle);
  assign bus.frame_done   = w_frame_done;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_cpu_frame_ctrl.sv
// Directed bench for cpu_frame_ctrl: DEPTH=64/RD_LAT=1 and DEPTH=256/RD_LAT=3 instances.
module tb_cpu_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;  // 0: 64-deep instance, 1: 256-deep instance
  logic drv_load_req = 1'b0;
  logic drv_in_valid = 1'b0;
  logic drv_dec_done = 1'b0;

  always #5 clk = ~clk;

  cpu_frame_ctrl_if if_a ();
  cpu_frame_ctrl_if if_b ();

  assign if_a.load_req = !sel && drv_load_req;
  assign if_a.in_valid = !sel && drv_in_valid;
  assign if_a.dec_done = !sel && drv_dec_done;
  assign if_b.load_req = sel && drv_load_req;
  assign if_b.in_valid = sel && drv_in_valid;
  assign if_b.dec_done = sel && drv_dec_done;

  cpu_frame_ctrl #(.ADDR_WIDTH(8), .DEPTH(64), .RD_LAT(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  cpu_frame_ctrl #(.ADDR_WIDTH(8), .DEPTH(256), .RD_LAT(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  logic o_busy, o_ready, o_ena, o_wr, o_rd, o_ov, o_start, o_fd, o_err;
  assign o_busy  = sel ? if_b.busy         : if_a.busy;
  assign o_ready = sel ? if_b.in_ready     : if_a.in_ready;
  assign o_ena   = sel ? if_b.cpu_addr_ena : if_a.cpu_addr_ena;
  assign o_wr    = sel ? if_b.mem_wr_en    : if_a.mem_wr_en;
  assign o_rd    = sel ? if_b.mem_rd_en    : if_a.mem_rd_en;
  assign o_ov    = sel ? if_b.out_valid    : if_a.out_valid;
  assign o_start = sel ? if_b.dec_start    : if_a.dec_start;
  assign o_fd    = sel ? if_b.frame_done   : if_a.frame_done;
  assign o_err   = sel ? if_b.err          : if_a.err;

  logic [8:0] outs_a, outs_b;
  assign outs_a = {if_a.busy, if_a.in_ready, if_a.cpu_addr_ena, if_a.mem_wr_en, if_a.mem_rd_en,
                   if_a.out_valid, if_a.dec_start, if_a.frame_done, if_a.err};
  assign outs_b = {if_b.busy, if_b.in_ready, if_b.cpu_addr_ena, if_b.mem_wr_en, if_b.mem_rd_en,
                   if_b.out_valid, if_b.dec_start, if_b.frame_done, if_b.err};

  // Model of the external address generator: count while enabled, else clear
  int m_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_addr <= 0;
    else        m_addr <= o_ena ? m_addr + 1 : 0;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int wr_n, wr_bad, rd_n, rd_bad, ov_n, start_n, fd_n, ena_n, stray_n;
  int first_rd, last_rd, last_ov, fd_cyc, dd_cyc;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_n = 0; wr_bad = 0; rd_n = 0; rd_bad = 0; ov_n = 0; start_n = 0; fd_n = 0;
    ena_n = 0; stray_n = 0; first_rd = -1; last_rd = -1; last_ov = -1; fd_cyc = -1;
    dd_cyc = -1;
  endtask

  // Sample the current cycle at the falling edge, then step past the next rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_wr) begin
      if (m_addr != wr_n) wr_bad++;
      wr_n++;
    end
    if (o_rd) begin
      if (m_addr != rd_n) rd_bad++;
      if (rd_n == 0) first_rd = cyc;
      rd_n++;
      last_rd = cyc;
    end
    if (o_ov) begin
      ov_n++;
      last_ov = cyc;
    end
    if (o_start) start_n++;
    if (o_fd) begin
      fd_n++;
      fd_cyc = cyc;
    end
    if (o_ena) ena_n++;
    if (o_ena && !o_wr && !o_rd) stray_n++;
    if (drv_dec_done) dd_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv_load_req = 1'b0;
    drv_in_valid = 1'b0;
    drv_dec_done = 1'b0;
    rst_n = 1'b0;
    #3;
    check("reset_outs_a", outs_a, 0);
    check("reset_outs_b", outs_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_beats(input int n);
    drv_in_valid = 1'b1;
    repeat (n) tick();
    drv_in_valid = 1'b0;
  endtask

  task automatic pulse_req();
    drv_load_req = 1'b1;
    tick();
    drv_load_req = 1'b0;
  endtask

  task automatic pulse_done();
    drv_dec_done = 1'b1;
    tick();
    drv_dec_done = 1'b0;
  endtask

  // Run until busy falls, bounded
  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", o_busy, 0);
  endtask

  task automatic full_frame(input int depth);
    pulse_req();
    load_beats(depth);
    tick();
    pulse_done();
    wait_idle(depth + 20);
  endtask

  initial begin
    clear_mon();
    do_reset();

    // Nominal frame, 64 deep, read latency 1
    clear_mon();
    pulse_req();
    check("ready_after_req", o_ready, 1);
    check("busy_after_req", o_busy, 1);
    load_beats(64);
    check("dec_start_after_last_beat", o_start, 1);
    repeat (10) tick();
    pulse_done();
    check("gap_no_read", {o_rd, o_ena}, 0);
    wait_idle(200);
    check("nom_wr_n", wr_n, 64);
    check("nom_wr_addr", wr_bad, 0);
    check("nom_start_n", start_n, 1);
    check("nom_rd_n", rd_n, 64);
    check("nom_rd_addr", rd_bad, 0);
    check("nom_ov_n", ov_n, 64);
    check("nom_fd_n", fd_n, 1);
    check("nom_fd_on_last_ov", fd_cyc, last_ov);
    check("nom_fd_lat", fd_cyc - last_rd, 1);
    check("nom_first_rd", first_rd, dd_cyc + 2);
    check("nom_busy_low", cyc + 1, first_rd + 64 + 1);
    check("nom_err", o_err, 0);
    check("nom_stray_ena", stray_n, 0);

    // Delayed first beat, dec_done during LOAD, load_req during UNLOAD
    clear_mon();
    pulse_req();
    for (int i = 0; i < 5; i++) begin
      drv_dec_done = (i == 2);
      tick();
    end
    drv_dec_done = 1'b0;
    check("wait_no_wr", wr_n, 0);
    check("wait_no_ena", ena_n, 0);
    check("load_ignores_done", {o_busy, o_ready}, 2'b11);
    load_beats(64);
    check("dly_wr_addr", wr_bad, 0);
    check("dly_dec_start", o_start, 1);
    tick();
    repeat (5) tick();
    check("dec_wait_holds", {o_busy, 1'(rd_n != 0)}, 2'b10);
    pulse_done();
    tick();
    repeat (10) tick();
    pulse_req();
    check("unload_ignores_req", {o_busy, o_rd}, 2'b11);
    wait_idle(200);
    check("dly_rd_n", rd_n, 64);
    check("dly_rd_addr", rd_bad, 0);
    check("dly_fd_n", fd_n, 1);
    check("dly_start_n", start_n, 1);
    repeat (4) tick();
    check("req_not_queued", {o_busy, o_ready}, 0);

    // Underrun after 17 beats
    clear_mon();
    pulse_req();
    load_beats(17);
    tick();
    check("underrun_err", o_err, 1);
    check("underrun_idle", o_busy, 0);
    check("underrun_ena", o_ena, 0);
    check("underrun_no_start", start_n, 0);
    check("underrun_wr_n", wr_n, 17);
    pulse_req();
    check("req_clears_err", {o_err, o_ready}, 2'b01);
    load_beats(64);
    tick();
    pulse_done();
    wait_idle(200);
    check("after_underrun_fd", fd_n, 1);

    // Full 256-word frame, read latency 3, dec_done on first wait cycle
    sel = 1'b1;
    do_reset();
    clear_mon();
    pulse_req();
    load_beats(255);
    check("deep_no_early_start", {o_start, o_ready}, 2'b01);
    load_beats(1);
    check("deep_dec_start", o_start, 1);
    tick();
    pulse_done();
    wait_idle(600);
    check("deep_wr_n", wr_n, 256);
    check("deep_wr_addr", wr_bad, 0);
    check("deep_rd_n", rd_n, 256);
    check("deep_rd_addr", rd_bad, 0);
    check("deep_ov_n", ov_n, 256);
    check("deep_fd_n", fd_n, 1);
    check("deep_fd_on_last_ov", fd_cyc, last_ov);
    check("deep_fd_lat", fd_cyc - last_rd, 3);
    check("deep_first_rd", first_rd, dd_cyc + 2);
    check("deep_busy_low", cyc + 1, first_rd + 256 + 3);

    // Reset asserted mid-UNLOAD, then a clean frame
    sel = 1'b0;
    do_reset();
    clear_mon();
    pulse_req();
    load_beats(64);
    tick();
    pulse_done();
    tick();
    repeat (20) tick();
    check("pre_reset_rd", o_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
    full_frame(64);
    check("rst_wr_addr", wr_bad, 0);
    check("rst_rd_addr", rd_bad, 0);
    check("rst_rd_n", rd_n, 64);
    check("rst_ov_n", ov_n, 64);
    check("rst_fd_n", fd_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
